// File: rtl/reverb_pkg.sv
// Shared reverb types: mixer FSM states, mix width and the wet-weight helper.
package reverb_pkg;

    localparam int MIX_WIDTH = 8;

    typedef enum logic [1:0] {
        BYPASS_S,
        FADE_IN_S,
        ACTIVE_S,
        FADE_OUT_S
    } mixer_state_t;

    // Full-scale mix maps to weight 256 so that 255 passes wet through exactly.
    function automatic logic [MIX_WIDTH:0] wet_weight(input logic [MIX_WIDTH-1:0] m);
        return (m == {MIX_WIDTH{1'b1}}) ? {1'b1, {MIX_WIDTH{1'b0}}} : {1'b0, m};
    endfunction

endpackage

// File: rtl/mix_slew_limiter.sv
// Effective mix weight register, moving toward its target once per tick.
// WET_DRY_MIXER_SLEW_EN enables rate limiting; otherwise the target loads directly.
module mix_slew_limiter
    import reverb_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 tick_i,
    input  logic [MIX_WIDTH-1:0] target_i,
    input  logic [MIX_WIDTH-1:0] step_i,
    output logic [MIX_WIDTH-1:0] mix_cur_o
);

    logic [MIX_WIDTH-1:0] r_mix_cur;
    logic [MIX_WIDTH-1:0] w_next;

`ifdef WET_DRY_MIXER_SLEW_EN
    logic                 w_up;
    logic [MIX_WIDTH-1:0] w_diff;
    logic [MIX_WIDTH-1:0] w_move;

    always_comb begin
        w_up   = target_i > r_mix_cur;
        w_diff = w_up ? (target_i - r_mix_cur) : (r_mix_cur - target_i);
        w_move = (w_diff < step_i) ? w_diff : step_i;
        w_next = w_up ? (r_mix_cur + w_move) : (r_mix_cur - w_move);
    end
`else
    logic w_unused_step;
    assign w_unused_step = ^step_i;
    assign w_next        = target_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_mix_cur <= '0;
        else if (tick_i)
            r_mix_cur <= w_next;
    end

    assign mix_cur_o = r_mix_cur;

endmodule

// File: rtl/wet_dry_mixer.sv
// Wet/dry crossfader with click-free enable/disable fades and a fixed 3-stage pipeline.
// Slewing is enabled by defining WET_DRY_MIXER_SLEW_EN.
module wet_dry_mixer
    import reverb_pkg::*;
#(
    parameter int DWIDTH    = 16,
    parameter int SLEW_STEP = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     sample_tick_i,
    input  logic                     enable_i,
    input  logic [MIX_WIDTH-1:0]     mix_i,
    input  logic signed [DWIDTH-1:0] dry_i,
    input  logic signed [DWIDTH-1:0] wet_i,
    output logic signed [DWIDTH-1:0] data_o,
    output logic                     valid_o,
    output logic                     busy_o
);

    localparam int PW = DWIDTH + 10;

    mixer_state_t         r_state;
    logic                 r_busy;
    logic [MIX_WIDTH-1:0] w_mix_cur;
    logic [MIX_WIDTH-1:0] w_target;
    logic                 w_slew_tick;

    assign w_target    = (r_state == FADE_OUT_S) ? '0 : mix_i;
    assign w_slew_tick = sample_tick_i && (r_state != BYPASS_S);

    mix_slew_limiter u_slew (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .tick_i    (w_slew_tick),
        .target_i  (w_target),
        .step_i    (MIX_WIDTH'(SLEW_STEP)),
        .mix_cur_o (w_mix_cur)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= BYPASS_S;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (r_state == FADE_IN_S) || (r_state == FADE_OUT_S);
            case (r_state)
                BYPASS_S:   if (enable_i) r_state <= FADE_IN_S;
                // Disable wins over arrival so a late drop of enable still fades out.
                FADE_IN_S:  if (!enable_i)              r_state <= FADE_OUT_S;
                            else if (w_mix_cur == mix_i) r_state <= ACTIVE_S;
                ACTIVE_S:   if (!enable_i) r_state <= FADE_OUT_S;
                FADE_OUT_S: if (enable_i)               r_state <= FADE_IN_S;
                            else if (w_mix_cur == '0)    r_state <= BYPASS_S;
                default:    r_state <= BYPASS_S;
            endcase
        end
    end

    logic signed [DWIDTH-1:0] r_dry, r_wet;
    logic [MIX_WIDTH:0]       r_w;
    logic signed [PW-1:0]     r_pd, r_pw;
    logic signed [DWIDTH-1:0] r_data;
    logic [2:0]               r_vld_pipe;
    logic signed [9:0]        w_wdry, w_wwet;
    logic signed [PW-1:0]     w_sum;

    assign w_wwet = {1'b0, r_w};
    assign w_wdry = {1'b0, 9'(9'd256 - r_w)};
    assign w_sum  = r_pd + r_pw;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dry      <= '0;
            r_wet      <= '0;
            r_w        <= '0;
            r_pd       <= '0;
            r_pw       <= '0;
            r_data     <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1:0], sample_tick_i};
            if (sample_tick_i) begin
                r_dry <= dry_i;
                r_wet <= wet_i;
                r_w   <= wet_weight(w_mix_cur);
            end
            if (r_vld_pipe[0]) begin
                r_pd <= PW'(r_dry) * PW'(w_wdry);
                r_pw <= PW'(r_wet) * PW'(w_wwet);
            end
            // Convex combination always fits DWIDTH; arithmetic shift floors toward -inf.
            if (r_vld_pipe[1])
                r_data <= DWIDTH'(w_sum >>> 8);
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_vld_pipe[2];
    assign busy_o  = r_busy;

endmodule
